// File: rtl/flash256k_pe_ctrl_if.sv
// APB target bus bundle for the FLASH256K program/erase sequencer.
interface flash256k_pe_ctrl_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/flash256k_pe_ctrl.sv
// APB-programmable program/erase timing sequencer for the FLASH256K user flash.
// Optional IE register and irq output are enabled by defining FLASH_PE_CTRL_IRQ_EN.
module flash256k_pe_ctrl #(
    parameter int unsigned T_NVS   = 3,
    parameter int unsigned T_PGS   = 4,
    parameter int unsigned T_PROG  = 5,
    parameter int unsigned T_ERASE = 10,
    parameter int unsigned T_NVH   = 3,
    parameter int unsigned T_RCV   = 2,
    parameter int unsigned CNT_W   = 24
) (
    input  logic                clk,
    input  logic                rst_i,
    flash256k_pe_ctrl_if.slave  apb,
    output logic [6:0]          fl_xadr,
    output logic [5:0]          fl_yadr,
    output logic [31:0]         fl_din,
    output logic                fl_xe,
    output logic                fl_ye,
    output logic                fl_erase,
    output logic                fl_prog,
    output logic                fl_nvstr,
    output logic                busy
`ifdef FLASH_PE_CTRL_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [7:0] AddrCtrl   = 8'h00;
    localparam logic [7:0] AddrAddr   = 8'h04;
    localparam logic [7:0] AddrData   = 8'h08;
    localparam logic [7:0] AddrStatus = 8'h0C;
`ifdef FLASH_PE_CTRL_IRQ_EN
    localparam logic [7:0] AddrIe     = 8'h10;
`endif

    // Counter reload values: each state lasts exactly its interval.
    localparam logic [CNT_W-1:0] LdNvs   = CNT_W'(T_NVS - 1);
    localparam logic [CNT_W-1:0] LdPgs   = CNT_W'(T_PGS - 1);
    localparam logic [CNT_W-1:0] LdProg  = CNT_W'(T_PROG - 1);
    localparam logic [CNT_W-1:0] LdErase = CNT_W'(T_ERASE - 1);
    localparam logic [CNT_W-1:0] LdNvh   = CNT_W'(T_NVH - 1);
    localparam logic [CNT_W-1:0] LdRcv   = CNT_W'(T_RCV - 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StNvs, StPgm, StErs, StHold, StRcv
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              erase_op_q, erase_op_d;
    logic [12:0]       addr_q;
    logic [31:0]       data_q;
    logic              done_q, err_q;
    logic              done_set;

    logic access, wr, perr, wr_ok, mapped;
    logic sel_ctrl, sel_addr, sel_data, sel_status;
    logic start_prog, start_erase, cnt_zero;

`ifdef FLASH_PE_CTRL_IRQ_EN
    logic sel_ie;
    logic ie_q, irq_q;
`endif

    assign busy     = (state_q != StIdle);
    assign cnt_zero = (cnt_q == '0);

    // Register decode
    assign access     = apb.psel & apb.penable;
    assign wr         = access & apb.pwrite;
    assign sel_ctrl   = (apb.paddr == AddrCtrl);
    assign sel_addr   = (apb.paddr == AddrAddr);
    assign sel_data   = (apb.paddr == AddrData);
    assign sel_status = (apb.paddr == AddrStatus);
`ifdef FLASH_PE_CTRL_IRQ_EN
    assign sel_ie     = (apb.paddr == AddrIe);
    assign mapped     = sel_ctrl | sel_addr | sel_data | sel_status | sel_ie;
`else
    assign mapped     = sel_ctrl | sel_addr | sel_data | sel_status;
`endif

    // Any error cancels the write and latches ERR.
    assign perr = access & (~mapped
                 | (apb.pwrite & busy & (sel_ctrl | sel_addr | sel_data))
                 | (apb.pwrite & sel_ctrl & (&apb.pwdata[1:0])));
    assign wr_ok       = wr & ~perr;
    assign start_prog  = wr_ok & sel_ctrl & apb.pwdata[0];
    assign start_erase = wr_ok & sel_ctrl & apb.pwdata[1];

    assign apb.pready  = 1'b1;
    assign apb.pslverr = perr;

    always_comb begin
        apb.prdata = '0;
        if (apb.psel && !apb.pwrite) begin
            if (sel_addr)        apb.prdata = {19'b0, addr_q};
            else if (sel_data)   apb.prdata = data_q;
            else if (sel_status) apb.prdata = {29'b0, err_q, done_q, busy};
`ifdef FLASH_PE_CTRL_IRQ_EN
            else if (sel_ie)     apb.prdata = {31'b0, ie_q};
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        erase_op_d = erase_op_q;
        done_set   = 1'b0;
        if (state_q != StIdle && !cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (start_prog || start_erase) begin
                    state_d    = StSetup;
                    cnt_d      = LdNvs;
                    erase_op_d = start_erase;
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    if (erase_op_q) begin
                        state_d = StErs;
                        cnt_d   = LdErase;
                    end else begin
                        state_d = StNvs;
                        cnt_d   = LdPgs;
                    end
                end
            end
            StNvs: begin
                if (cnt_zero) begin
                    state_d = StPgm;
                    cnt_d   = LdProg;
                end
            end
            StPgm, StErs: begin
                if (cnt_zero) begin
                    state_d = StHold;
                    cnt_d   = LdNvh;
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    state_d = StRcv;
                    cnt_d   = LdRcv;
                end
            end
            StRcv: begin
                if (cnt_zero) begin
                    state_d  = StIdle;
                    done_set = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Flash pin decode from the current state
    always_comb begin
        fl_xe    = 1'b0;
        fl_ye    = 1'b0;
        fl_prog  = 1'b0;
        fl_erase = 1'b0;
        fl_nvstr = 1'b0;
        fl_din   = '0;
        unique case (state_q)
            StSetup: begin
                fl_xe    = 1'b1;
                fl_prog  = ~erase_op_q;
                fl_erase = erase_op_q;
            end
            StNvs: begin
                fl_xe    = 1'b1;
                fl_prog  = 1'b1;
                fl_nvstr = 1'b1;
            end
            StPgm: begin
                fl_xe    = 1'b1;
                fl_prog  = 1'b1;
                fl_nvstr = 1'b1;
                fl_ye    = 1'b1;
                fl_din   = data_q;
            end
            StErs: begin
                fl_xe    = 1'b1;
                fl_erase = 1'b1;
                fl_nvstr = 1'b1;
            end
            StHold: begin
                fl_xe    = 1'b1;
                fl_nvstr = 1'b1;
            end
            default: ;
        endcase
    end

    assign fl_xadr = addr_q[12:6];
    assign fl_yadr = addr_q[5:0];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            erase_op_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            erase_op_q <= erase_op_d;
            if (wr_ok && sel_addr) addr_q <= apb.pwdata[12:0];
            if (wr_ok && sel_data) data_q <= apb.pwdata;
            // Hardware set beats a simultaneous W1C.
            if (done_set)                                   done_q <= 1'b1;
            else if (wr_ok && sel_status && apb.pwdata[1])  done_q <= 1'b0;
            if (perr)                                       err_q  <= 1'b1;
            else if (wr_ok && sel_status && apb.pwdata[2])  err_q  <= 1'b0;
        end
    end

`ifdef FLASH_PE_CTRL_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst_i) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_ok && sel_ie) ie_q <= apb.pwdata[0];
            irq_q <= done_q & ie_q;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_flash256k_pe_ctrl.sv
// Scoreboard bench for flash256k_pe_ctrl: APB accesses plus per-run flash pin timing checks.
module tb_flash256k_pe_ctrl;

    logic        clk;
    logic        rst_i;
    logic [6:0]  fl_xadr;
    logic [5:0]  fl_yadr;
    logic [31:0] fl_din;
    logic        fl_xe, fl_ye, fl_erase, fl_prog, fl_nvstr, busy;
`ifdef FLASH_PE_CTRL_IRQ_EN
    logic        irq;
`endif

    flash256k_pe_ctrl_if apb_if ();

    flash256k_pe_ctrl dut (
        .clk      (clk),
        .rst_i    (rst_i),
        .apb      (apb_if),
        .fl_xadr  (fl_xadr),
        .fl_yadr  (fl_yadr),
        .fl_din   (fl_din),
        .fl_xe    (fl_xe),
        .fl_ye    (fl_ye),
        .fl_erase (fl_erase),
        .fl_prog  (fl_prog),
        .fl_nvstr (fl_nvstr),
        .busy     (busy)
`ifdef FLASH_PE_CTRL_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          busy_n;
        int          prog_n;
        int          erase_n;
        int          nvstr_n;
        int          ye_n;
        logic [31:0] din;
    } run_t;

    run_t        run_q[$];
    logic [31:0] rd_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit abort_run = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Run monitor: counts pin-high cycles while busy, scores them when busy falls.
    int busy_n = 0, prog_n = 0, erase_n = 0, nvstr_n = 0, ye_n = 0, ye_bad = 0;
    bit busy_prev = 1'b0;
    always @(negedge clk) begin
        run_t e;
        if (busy) begin
            busy_n++;
            if (fl_prog)  prog_n++;
            if (fl_erase) erase_n++;
            if (fl_nvstr) nvstr_n++;
            if (fl_ye) begin
                ye_n++;
                if (run_q.size() > 0 &&
                    (fl_din !== run_q[0].din || !(fl_xe && fl_prog && fl_nvstr))) ye_bad++;
            end
        end else if (busy_prev) begin
            if (run_q.size() == 0) begin
                check_eq("run_unexpected", 32'd1, 32'd0);
            end else begin
                e = run_q.pop_front();
                if (abort_run) begin
                    abort_run = 1'b0;
                end else begin
                    check_eq("run_busy_cycles", busy_n, e.busy_n);
                    check_eq("run_prog_cycles", prog_n, e.prog_n);
                    check_eq("run_erase_cycles", erase_n, e.erase_n);
                    check_eq("run_nvstr_cycles", nvstr_n, e.nvstr_n);
                    check_eq("run_ye_cycles", ye_n, e.ye_n);
                    check_eq("run_ye_pins_din", ye_bad, 0);
                end
            end
            busy_n = 0; prog_n = 0; erase_n = 0; nvstr_n = 0; ye_n = 0; ye_bad = 0;
        end
        busy_prev = busy;
    end

    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
        @(negedge clk);
        apb_if.psel    = 1'b1;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = wr;
        apb_if.paddr   = a;
        apb_if.pwdata  = wd;
        @(negedge clk);
        apb_if.penable = 1'b1;
        #1;
        rd  = apb_if.prdata;
        err = apb_if.pslverr;
        @(posedge clk);
        #1;
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] a, input logic [31:0] exp,
                             input logic exp_err);
        logic [31:0] rd;
        logic        err;
        rd_q.push_back(exp);
        apb_xfer(1'b0, a, 32'h0, rd, err);
        check_eq(tag, rd, rd_q.pop_front());
        check_eq({tag, "_pslverr"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic wr_expect(input string tag, input logic [7:0] a, input logic [31:0] d,
                             input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, a, d, rd, err);
        check_eq({tag, "_pslverr"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic push_prog(input logic [31:0] din);
        run_t r;
        r.busy_n = 17; r.prog_n = 12; r.erase_n = 0; r.nvstr_n = 12; r.ye_n = 5; r.din = din;
        run_q.push_back(r);
    endtask

    task automatic push_erase();
        run_t r;
        r.busy_n = 18; r.prog_n = 0; r.erase_n = 13; r.nvstr_n = 13; r.ye_n = 0; r.din = '0;
        run_q.push_back(r);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] pins();
        return {26'b0, busy, fl_xe, fl_ye, fl_erase, fl_prog, fl_nvstr};
    endfunction

    initial begin
        bit seen;
        rst_i          = 1'b1;
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
        apb_if.paddr   = '0;
        apb_if.pwdata  = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_pins", pins(), 32'h0);
        check_eq("rst_pready", {31'b0, apb_if.pready}, 32'h1);
        check_eq("rst_din", fl_din, 32'h0);
        check_eq("rst_xyadr", {19'b0, fl_xadr, fl_yadr}, 32'h0);
`ifdef FLASH_PE_CTRL_IRQ_EN
        check_eq("rst_irq", {31'b0, irq}, 32'h0);
`endif
        rd_expect("rst_addr", 8'h04, 32'h0, 1'b0);
        rd_expect("rst_data", 8'h08, 32'h0, 1'b0);
        rd_expect("rst_status", 8'h0C, 32'h0, 1'b0);
        rd_expect("ctrl_reads_zero", 8'h00, 32'h0, 1'b0);

        // Program
        wr_expect("prog_addr", 8'h04, 32'hFFFF_0ABC, 1'b0);
        wr_expect("prog_data", 8'h08, 32'hDEAD_BEEF, 1'b0);
        check_eq("prog_xadr", {25'b0, fl_xadr}, 32'h2A);
        check_eq("prog_yadr", {26'b0, fl_yadr}, 32'h3C);
        rd_expect("prog_addr_rb", 8'h04, 32'h0ABC, 1'b0);
        push_prog(32'hDEAD_BEEF);
        wr_expect("prog_start", 8'h00, 32'h1, 1'b0);
        wait_idle("prog");
        rd_expect("prog_status", 8'h0C, 32'h2, 1'b0);
        wr_expect("prog_clr", 8'h0C, 32'h2, 1'b0);

        // Erase
        wr_expect("ers_addr", 8'h04, 32'h1FC0, 1'b0);
        check_eq("ers_xadr", {25'b0, fl_xadr}, 32'h7F);
        push_erase();
        wr_expect("ers_start", 8'h00, 32'h2, 1'b0);
        wait_idle("ers");
        rd_expect("ers_status", 8'h0C, 32'h2, 1'b0);
        wr_expect("ers_clr", 8'h0C, 32'h2, 1'b0);

        // Writes while busy are rejected and flag ERR
        wr_expect("bz_addr", 8'h04, 32'h0ABC, 1'b0);
        push_prog(32'hDEAD_BEEF);
        wr_expect("bz_start", 8'h00, 32'h1, 1'b0);
        wr_expect("bz_ctrl", 8'h00, 32'h1, 1'b1);
        wr_expect("bz_addr_wr", 8'h04, 32'h0005, 1'b1);
        rd_expect("bz_status", 8'h0C, 32'h5, 1'b0);
        wait_idle("bz");
        rd_expect("bz_status_end", 8'h0C, 32'h6, 1'b0);
        rd_expect("bz_addr_kept", 8'h04, 32'h0ABC, 1'b0);
        wr_expect("bz_clr", 8'h0C, 32'h6, 1'b0);
        rd_expect("bz_status_clr", 8'h0C, 32'h0, 1'b0);

        // Illegal CTRL value, unmapped address, no-op CTRL
        wr_expect("ctrl3", 8'h00, 32'h3, 1'b1);
        @(negedge clk);
        check_eq("ctrl3_no_busy", {31'b0, busy}, 32'h0);
        rd_expect("ctrl3_status", 8'h0C, 32'h4, 1'b0);
        rd_expect("unmapped_rd", 8'h20, 32'h0, 1'b1);
        wr_expect("err_clr", 8'h0C, 32'h4, 1'b0);
        wr_expect("ctrl0", 8'h00, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("ctrl0_no_busy", {31'b0, busy}, 32'h0);
        rd_expect("ctrl0_status", 8'h0C, 32'h0, 1'b0);
`ifndef FLASH_PE_CTRL_IRQ_EN
        wr_expect("ie_unmapped", 8'h10, 32'h1, 1'b1);
        rd_expect("ie_unmapped_status", 8'h0C, 32'h4, 1'b0);
        wr_expect("ie_err_clr", 8'h0C, 32'h4, 1'b0);
`endif

        // Reset mid-PGM, then a clean run
        wr_expect("rr_data", 8'h08, 32'h1234_5678, 1'b0);
        push_prog(32'h1234_5678);
        wr_expect("rr_start", 8'h00, 32'h1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (fl_ye) seen = 1'b1;
        end
        check_eq("rr_reached_pgm", {31'b0, seen}, 32'h1);
        abort_run = 1'b1;
        rst_i     = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_eq("rr_pins_cleared", pins(), 32'h0);
        rd_expect("rr_addr_reset", 8'h04, 32'h0, 1'b0);
        wr_expect("rr2_addr", 8'h04, 32'h0041, 1'b0);
        wr_expect("rr2_data", 8'h08, 32'hA5A5_5A5A, 1'b0);
        push_prog(32'hA5A5_5A5A);
        wr_expect("rr2_start", 8'h00, 32'h1, 1'b0);
        wait_idle("rr2");
        rd_expect("rr2_status", 8'h0C, 32'h2, 1'b0);
        wr_expect("rr2_clr", 8'h0C, 32'h2, 1'b0);

`ifdef FLASH_PE_CTRL_IRQ_EN
        // Interrupt follows DONE by one cycle
        wr_expect("irq_ie", 8'h10, 32'h1, 1'b0);
        rd_expect("irq_ie_rb", 8'h10, 32'h1, 1'b0);
        push_prog(32'hA5A5_5A5A);
        wr_expect("irq_start", 8'h00, 32'h1, 1'b0);
        wait_idle("irq");
        check_eq("irq_low_at_done", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check_eq("irq_rise", {31'b0, irq}, 32'h1);
        wr_expect("irq_clr", 8'h0C, 32'h2, 1'b0);
        @(negedge clk);
        check_eq("irq_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check_eq("irq_fall", {31'b0, irq}, 32'h0);
`endif

        repeat (3) @(negedge clk);
        check_eq("runs_left", run_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
